// File: rtl/uart_receiver_if.sv
// Byte delivery channel between the UART receiver and the core logic.
// Latency: none, this is wiring only.
// Backpressure: the consumer holds rx_ready low to keep RxData/rx_valid parked in the receiver.
//
// Signals:
//   RxData    8  received byte, valid while rx_valid=1
//   rx_valid  1  receiver holding register is full
//   rx_ready  1  consumer takes RxData on a cycle with rx_valid & rx_ready
interface uart_receiver_if;
  logic [7:0] RxData;
  logic       rx_valid;
  logic       rx_ready;

  // master: the receiver that produces bytes; slave: the core that consumes them
  modport master (output RxData, output rx_valid, input rx_ready);
  modport slave  (input RxData, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, LSB first, mid-bit sampling, byte delivered through a valid/ready holding register.
// Latency: RxD is synchronised over 2 cycles; rx_valid rises the cycle after the stop-bit sample.
// Backpressure: one-byte holding register; a frame completing while it is full and not taken is dropped with an overrun pulse.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   RxD          serial line, idle high, asynchronous to clk
//   rx           byte channel (RxData / rx_valid / rx_ready), master side
//   busy         high while a frame is being decoded (START, DATA, STOP)
//   frame_error  1-cycle pulse: stop bit sampled low, byte discarded
//   overrun      1-cycle pulse: good frame completed while the register was full and not being taken
module uart_receiver #(
  parameter int clk_freq    = 50_000_000,
  parameter int baud_rate   = 115200,
  parameter int div_counter = clk_freq / baud_rate  // clocks per bit, 4..65535
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            RxD,
  uart_receiver_if.master rx,
  output logic            busy,
  output logic            frame_error,
  output logic            overrun
);

  // Terminal counts: full bit time and half bit time (floor), both counted from 0.
  localparam logic [15:0] bit_last  = 16'(div_counter - 1);
  localparam logic [15:0] half_last = 16'(div_counter / 2 - 1);

  typedef enum logic [2:0] {
    BREAK,
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t      state;
  logic        rx_meta;
  logic        rxs;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta     <= 1'b1;
      rxs         <= 1'b1;
      state       <= BREAK;
      cnt         <= 16'd0;
      bit_idx     <= 3'd0;
      shreg       <= 8'd0;
      rx.RxData   <= 8'd0;
      rx.rx_valid <= 1'b0;
      busy        <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      // Two-flop synchroniser; every decision below looks only at rxs.
      rx_meta <= RxD;
      rxs     <= rx_meta;

      frame_error <= 1'b0;
      overrun     <= 1'b0;

      // Consumer handshake. A good stop sample in this same cycle overrides
      // this below, so accept-and-reload keeps rx_valid high.
      if (rx.rx_valid && rx.rx_ready) begin
        rx.rx_valid <= 1'b0;
      end

      case (state)
        // A low line (reset mid-frame, break after a framing error) must be
        // seen high once before any falling edge counts as a start bit.
        BREAK: begin
          if (rxs) begin
            state <= IDLE;
          end
        end

        IDLE: begin
          if (!rxs) begin
            cnt   <= 16'd0;
            busy  <= 1'b1;
            state <= START;
          end
        end

        // Re-check the line half a bit in; a high line means a glitch.
        START: begin
          if (cnt == half_last) begin
            cnt <= 16'd0;
            if (rxs) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              bit_idx <= 3'd0;
              state   <= DATA;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        // Counting from mid start bit, each full bit time lands mid data bit.
        DATA: begin
          if (cnt == bit_last) begin
            cnt            <= 16'd0;
            shreg[bit_idx] <= rxs;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        STOP: begin
          if (cnt == bit_last) begin
            cnt  <= 16'd0;
            busy <= 1'b0;
            if (rxs) begin
              state <= IDLE;
              if (rx.rx_valid && !rx.rx_ready) begin
                // Register full and not drained this cycle: keep the old byte.
                overrun <= 1'b1;
              end else begin
                rx.RxData   <= shreg;
                rx.rx_valid <= 1'b1;
              end
            end else begin
              frame_error <= 1'b1;
              state       <= BREAK;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        default: begin
          state <= BREAK;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: two instances (16 and 13 clocks per bit)
// driven by a frame-level line generator; a scoreboard of expected bytes and
// flag counts is checked every cycle by a single compare process.
module tb_uart_receiver;

  localparam int CLK_P = 100;
  localparam int DIV0  = 16;  // 1_843_200 / 115200
  localparam int DIV1  = 13;  // 124_800 / 9600

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rxd [2];
  logic       rdy [2];
  logic [7:0] dat [2];
  logic       vld [2];
  logic       bsy [2];
  logic       fe  [2];
  logic       ov  [2];

  always #(CLK_P / 2) clk = ~clk;

  uart_receiver_if if0 ();
  uart_receiver_if if1 ();

  uart_receiver #(.clk_freq(1_843_200), .baud_rate(115200)) dut0 (
    .clk(clk), .reset_n(reset_n), .RxD(rxd[0]), .rx(if0.master),
    .busy(bsy[0]), .frame_error(fe[0]), .overrun(ov[0]));

  uart_receiver #(.clk_freq(124_800), .baud_rate(9600)) dut1 (
    .clk(clk), .reset_n(reset_n), .RxD(rxd[1]), .rx(if1.master),
    .busy(bsy[1]), .frame_error(fe[1]), .overrun(ov[1]));

  assign if0.rx_ready = rdy[0];
  assign if1.rx_ready = rdy[1];
  assign dat[0] = if0.RxData;
  assign dat[1] = if1.RxData;
  assign vld[0] = if0.rx_valid;
  assign vld[1] = if1.rx_valid;

  // ---------------------------------------------------------------- model
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [8:0] exp_q [$];          // {dut index, byte} in delivery order
  int         exp_fe [2] = '{0, 0};
  int         exp_ov [2] = '{0, 0};
  int         obs_fe [2] = '{0, 0};
  int         obs_ov [2] = '{0, 0};
  int         acc_cnt [2] = '{0, 0};
  int         busy_rise [2] = '{0, 0};
  int         run_len [2] = '{0, 0};
  int         last_run [2] = '{0, 0};
  logic [7:0] last_acc [2] = '{8'd0, 8'd0};
  logic       prev_vld [2] = '{1'b0, 1'b0};
  logic       prev_rdy [2] = '{1'b0, 1'b0};
  logic       prev_bsy [2] = '{1'b0, 1'b0};
  logic       prev_fe  [2] = '{1'b0, 1'b0};
  logic       prev_ov  [2] = '{1'b0, 1'b0};
  logic [7:0] prev_dat [2] = '{8'd0, 8'd0};
  logic [8:0] cmp_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Single compare process, sampling on the falling edge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset_n === 1'b1) begin
        if (vld[d] && rdy[d]) begin
          check("byte_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            cmp_e = exp_q.pop_front();
            check("byte_dut", 32'(cmp_e[8]), 32'(d));
            check("byte_value", 32'(dat[d]), 32'(cmp_e[7:0]));
          end
          acc_cnt[d]++;
          last_acc[d] = dat[d];
        end
        if (prev_vld[d] && !prev_rdy[d]) begin
          check("vld_held", 32'(vld[d]), 32'd1);
          check("dat_stable", 32'(dat[d]), 32'(prev_dat[d]));
        end
        if (vld[d] && !prev_vld[d]) begin
          check("flag_with_valid", 32'({fe[d], ov[d]}), 32'd0);
        end
        if (fe[d]) begin
          obs_fe[d]++;
          check("fe_one_cycle", 32'(prev_fe[d]), 32'd0);
        end
        if (ov[d]) begin
          obs_ov[d]++;
          check("ov_one_cycle", 32'(prev_ov[d]), 32'd0);
        end
        if (bsy[d] && !prev_bsy[d]) busy_rise[d]++;
        if (vld[d]) begin
          run_len[d]++;
        end else if (prev_vld[d]) begin
          last_run[d] = run_len[d];
          run_len[d]  = 0;
        end
      end
      prev_vld[d] = vld[d];
      prev_rdy[d] = rdy[d];
      prev_bsy[d] = bsy[d];
      prev_fe[d]  = fe[d];
      prev_ov[d]  = ov[d];
      prev_dat[d] = dat[d];
    end
  end

  // ------------------------------------------------------------ stimulus
  function automatic int bit_t(input int d, input int skew_pct);
    return ((d == 0) ? DIV0 : DIV1) * CLK_P * (100 + skew_pct) / 100;
  endfunction

  task automatic expect_byte(input int d, input logic [7:0] b);
    exp_q.push_back({1'(d), b});
  endtask

  task automatic set_rdy(input int d, input logic v);
    @(posedge clk);
    #1 rdy[d] = v;
  endtask

  // Leaves the line at the stop-bit level afterwards.
  task automatic send_frame(input int d, input logic [7:0] b, input logic stop, input int skew);
    int bt;
    bt = bit_t(d, skew);
    rxd[d] = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      rxd[d] = b[i];
      #(bt);
    end
    rxd[d] = stop;
    #(bt);
  endtask

  task automatic idle(input int d, input int nbits);
    rxd[d] = 1'b1;
    #(bit_t(d, 0) * nbits);
  endtask

  task automatic settle(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || obs_fe[0] != exp_fe[0] || obs_fe[1] != exp_fe[1] ||
            obs_ov[0] != exp_ov[0] || obs_ov[1] != exp_ov[1]) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check({name, "_bytes_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_fe_count"}, 32'(obs_fe[0] + obs_fe[1]), 32'(exp_fe[0] + exp_fe[1]));
    check({name, "_ov_count"}, 32'(obs_ov[0] + obs_ov[1]), 32'(exp_ov[0] + exp_ov[1]));
  endtask

  initial begin
    int bt;
    int br;
    reset_n = 1'b0;
    rxd[0] = 1'b1;
    rxd[1] = 1'b1;
    rdy[0] = 1'b0;
    rdy[1] = 1'b0;

    // Reset values
    repeat (4) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_RxData", 32'(dat[d]), 32'd0);
      check("rst_valid", 32'(vld[d]), 32'd0);
      check("rst_busy", 32'(bsy[d]), 32'd0);
      check("rst_flags", 32'({fe[d], ov[d]}), 32'd0);
    end
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: single frame 0xA5, consumer always ready
    set_rdy(0, 1'b1);
    expect_byte(0, 8'hA5);
    send_frame(0, 8'hA5, 1'b1, 0);
    idle(0, 2);
    settle("t1");
    check("t1_last_byte", 32'(last_acc[0]), 32'hA5);
    check("t1_valid_width", 32'(last_run[0]), 32'd1);

    // 2: back-to-back frames, no idle gap
    expect_byte(0, 8'h00);
    expect_byte(0, 8'hFF);
    expect_byte(0, 8'h55);
    send_frame(0, 8'h00, 1'b1, 0);
    send_frame(0, 8'hFF, 1'b1, 0);
    send_frame(0, 8'h55, 1'b1, 0);
    idle(0, 2);
    settle("t2");
    check("t2_accepted", 32'(acc_cnt[0]), 32'd4);

    // 3: consumer stalled, second frame overruns
    set_rdy(0, 1'b0);
    expect_byte(0, 8'h3C);
    exp_ov[0]++;
    send_frame(0, 8'h3C, 1'b1, 0);
    idle(0, 1);
    send_frame(0, 8'h81, 1'b1, 0);
    idle(0, 2);
    @(negedge clk);
    check("t3_valid_parked", 32'(vld[0]), 32'd1);
    check("t3_data_kept", 32'(dat[0]), 32'h3C);
    check("t3_overrun_once", 32'(obs_ov[0]), 32'd1);
    set_rdy(0, 1'b1);
    settle("t3");
    repeat (2) @(negedge clk);
    check("t3_valid_fell", 32'(vld[0]), 32'd0);

    // 4: bad stop bit, line held low, then a good frame
    exp_fe[0]++;
    expect_byte(0, 8'h12);
    send_frame(0, 8'h5A, 1'b0, 0);
    #(bit_t(0, 0) * 3);
    idle(0, 1);
    send_frame(0, 8'h12, 1'b1, 0);
    idle(0, 2);
    settle("t4");
    check("t4_fe_once", 32'(obs_fe[0]), 32'd1);
    check("t4_last_byte", 32'(last_acc[0]), 32'h12);

    // 5: glitch of 0.3 bit time is a false start
    br = busy_rise[0];
    rxd[0] = 1'b0;
    #(bit_t(0, 0) * 3 / 10);
    idle(0, 2);
    check("t5_busy_rose", 32'(busy_rise[0] - br), 32'd1);
    check("t5_busy_fell", 32'(bsy[0]), 32'd0);
    expect_byte(0, 8'hC3);
    send_frame(0, 8'hC3, 1'b1, 0);
    idle(0, 2);
    settle("t5");
    check("t5_last_byte", 32'(last_acc[0]), 32'hC3);

    // 6: reset during data bit 4 of 0x77, released while bit 7 (low) is on the line
    bt = bit_t(0, 0);
    rxd[0] = 1'b0;
    #(bt);
    for (int i = 0; i < 4; i++) begin
      rxd[0] = (8'h77 >> i) & 1;
      #(bt);
    end
    rxd[0] = 1'b1;
    #(bt / 2);
    check("t6_busy_mid_frame", 32'(bsy[0]), 32'd1);
    reset_n = 1'b0;
    #(2 * CLK_P);
    check("t6_rst_RxData", 32'(dat[0]), 32'd0);
    check("t6_rst_valid", 32'(vld[0]), 32'd0);
    check("t6_rst_busy", 32'(bsy[0]), 32'd0);
    check("t6_rst_flags", 32'({fe[0], ov[0]}), 32'd0);
    #(bt / 2 - 2 * CLK_P);
    rxd[0] = 1'b1;  // bit 5
    #(bt);
    rxd[0] = 1'b1;  // bit 6
    #(bt);
    rxd[0] = 1'b0;  // bit 7
    #(bt / 2);
    reset_n = 1'b1;
    #(bt / 2);
    idle(0, 3);
    check("t6_no_partial_byte", 32'(bsy[0] | vld[0]), 32'd0);
    expect_byte(0, 8'h99);
    send_frame(0, 8'h99, 1'b1, 0);
    idle(0, 2);
    settle("t6");
    check("t6_last_byte", 32'(last_acc[0]), 32'h99);

    // 7: transmitter clock skew +2% then -2%, back-to-back
    expect_byte(0, 8'h6B);
    expect_byte(0, 8'hD4);
    send_frame(0, 8'h6B, 1'b1, 2);
    send_frame(0, 8'hD4, 1'b1, -2);
    idle(0, 2);
    settle("t7");
    check("t0_total_bytes", 32'(acc_cnt[0]), 32'd10);

    // 8: second instance at 13 clocks per bit (odd divider), nominal and -2%
    set_rdy(1, 1'b1);
    expect_byte(1, 8'h3E);
    expect_byte(1, 8'hC1);
    send_frame(1, 8'h3E, 1'b1, 0);
    send_frame(1, 8'hC1, 1'b1, -2);
    idle(1, 2);
    settle("t8");
    check("t8_bytes", 32'(acc_cnt[1]), 32'd2);
    check("t8_last_byte", 32'(last_acc[1]), 32'hC1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
